mu0_mem_master: RTL and testbench
=================================

# mu0_mem_master

Bus initiator for the Mu0 memory bus. It takes single-word read/write requests from the Mu0 control/datapath over a valid/ready handshake and drives `mem_rq`, `rnw`, `addr` and the shared tristate `databus` toward the Mu0 memory. It returns captured read data or write completion as a one-cycle response. It sits between the CPU core and the memory and is the only bus master. It inserts configurable wait states and rejects out-of-range addresses locally.

## Interface
Parameters:
- `ADDR`, 12, address width
- `DATA`, 16, data/bus width
- `MEM`, 32, number of implemented memory words; legal addresses are 0..MEM-1
- `WAIT`, 0, extra access cycles beyond the first (0..15)

Ports:
- `clk`  in  1  single clock; all state on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `req_valid`  in  1  CPU request present
- `req_ready`  out  1  master can accept a request
- `req_write`  in  1  1=write, 0=read
- `req_addr`  in  ADDR  word address
- `req_wdata`  in  DATA  write data
- `rsp_valid`  out  1  one-cycle response pulse
- `rsp_rdata`  out  DATA  read data; valid with `rsp_valid` and held until the next response
- `rsp_err`  out  1  address out of range; valid with `rsp_valid`
- `mem_rq`  out  1  memory request
- `rnw`  out  1  1=read, 0=write
- `addr`  out  ADDR  memory address
- `databus`  inout  DATA  shared bus; driven only during write access, else `'z`

## Operation
- States:
  - IDLE: `req_ready`=1 (gated low while `rst`=1).
    - Accepts on `req_valid & req_ready`, latching write, addr and wdata.
    - If addr >= MEM, goes to RESP with err=1.
    - Otherwise goes to ACCESS with wait counter cleared.
  - ACCESS: `mem_rq`=1, `rnw`=~write, `addr`=latched addr.
    - Write: drives `databus`=latched wdata.
    - Read: releases `databus`.
    - Counter increments each cycle. On the cycle where counter==WAIT, a read captures `databus` into `rsp_rdata` at the closing edge. Then the state goes to RESP.
  - RESP: `mem_rq`=0, bus released, `rsp_valid`=1.
    - `rsp_err` as latched. On error, `rsp_rdata` is set to 0.
    - Next state is IDLE.
- `req_ready`=0 outside IDLE. Requests held by the CPU wait; the block has no buffering.
- When `mem_rq`=0, `rnw`=1 and `addr` holds its last value.
- RESP is the mandatory bus turnaround cycle. The master never drives `databus` in a cycle where `mem_rq & rnw` can be true.
- Write responses return `rsp_rdata` unchanged from the previous response.
- A rejected request (err) never asserts `mem_rq`.

## Timing
- Reset values:
  - `mem_rq`=0, `rnw`=1, `addr`=0, `databus`=z
  - `req_ready`=0 (while asserted)
  - `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0
  - state=IDLE
- Reset mid-operation: `mem_rq` and the bus driver drop asynchronously, so no memory write happens at the following edge. No response is issued.
- Latency with acceptance at edge E:
  - ACCESS occupies cycles E+1..E+1+WAIT.
  - `rsp_valid` is high in cycle E+2+WAIT.
  - `req_ready` returns in cycle E+3+WAIT.
- Error latency: `rsp_valid` is high in cycle E+1.
- Throughput: one access per WAIT+3 cycles back-to-back.
- Write commits at every ACCESS edge; repeated identical writes are harmless.

## Structure
- Shared package `mu0_pkg`:
  - state enum (IDLE, ACCESS, RESP)
  - ADDR/DATA/MEM defaults
  - `rnw` encoding constants (READ=1, WRITE=0)
- Sub-module `mu0_wait_ctr`: 4-bit clear/increment counter with a `done` output (count==WAIT).
- The tristate assign stays in the top module.

## Test plan
- **Write then read:** write 0xBEEF to addr 5 with WAIT=0, then read addr 5.
  - Write: `mem_rq`=1 and `rnw`=0 for 1 cycle, with `databus`=0xBEEF.
  - Read: `rsp_rdata`=0xBEEF and `rsp_err`=0, 2 cycles after accept.
- **Wait states:** WAIT=3, read addr 7 preloaded with 0x1234.
  - `mem_rq` high for 4 cycles.
  - `rsp_valid` at E+5 with 0x1234.
  - `req_ready` low for 5 cycles.
- **Out of range:** read addr 32 (MEM=32).
  - `mem_rq` never asserted.
  - `rsp_valid` at E+1 with `rsp_err`=1 and `rsp_rdata`=0.
- **Back-to-back:** `req_valid` held high for writes to addrs 1, 2, 3 (0x0001..0x0003).
  - Accepts every 3 cycles.
  - `databus`=z in every RESP cycle.
  - Memory contents verified.
- **Reset mid-write:** assert `rst` during ACCESS of a write of 0xAAAA to addr 9 (holding 0x5555).
  - `mem_rq`=0 immediately.
  - No `rsp_valid`.
  - addr 9 still reads 0x5555 after reset.
- **Bus contention check:** random read/write mix, 200 requests.
  - `databus` never multiply driven: no X, with an assertion that master drive implies `rnw`=0.

Source files
------------

// File: rtl/mu0_pkg.sv
// Shared constants for the Mu0 memory bus master: default widths, state codes and rnw encoding.
package mu0_pkg;

  localparam int unsigned AddrW    = 12;
  localparam int unsigned DataW    = 16;
  localparam int unsigned MemWords = 32;
  localparam int unsigned WaitCtrW = 4;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StAccess = 2'd1;
  localparam logic [1:0] StResp   = 2'd2;

  localparam logic RnwRead  = 1'b1;
  localparam logic RnwWrite = 1'b0;

endpackage

// File: rtl/mu0_wait_ctr.sv
// Access-length counter: cleared on accept, counts ACCESS cycles, flags the last one.
module mu0_wait_ctr
  import mu0_pkg::*;
#(
  parameter int unsigned WAIT = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_done
);

  localparam logic [WaitCtrW-1:0] WaitVal = WaitCtrW'(WAIT);

  logic [WaitCtrW-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + WaitCtrW'(1);
    end
  end

  assign o_done = (r_count == WaitVal);

endmodule

// File: rtl/mu0_mem_master.sv
// Single bus initiator for the Mu0 memory: one request at a time, wait states, local range check.
module mu0_mem_master
  import mu0_pkg::*;
#(
  parameter int unsigned ADDR = AddrW,
  parameter int unsigned DATA = DataW,
  parameter int unsigned MEM  = MemWords,
  parameter int unsigned WAIT = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [ADDR-1:0] req_addr,
  input  logic [DATA-1:0] req_wdata,
  output logic            rsp_valid,
  output logic [DATA-1:0] rsp_rdata,
  output logic            rsp_err,
  output logic            mem_rq,
  output logic            rnw,
  output logic [ADDR-1:0] addr,
  inout  wire  [DATA-1:0] databus
);

  // One extra bit so MEM == 2**ADDR still compares correctly.
  localparam logic [ADDR:0] MemLim = (ADDR+1)'(MEM);

  logic [1:0]      r_state;
  logic            r_write;
  logic            r_err;
  logic [ADDR-1:0] r_addr;
  logic [DATA-1:0] r_wdata;
  logic [DATA-1:0] r_rdata;

  logic w_idle;
  logic w_access;
  logic w_accept;
  logic w_in_range;
  logic w_done;
  logic w_drive;

  assign w_idle     = (r_state == StIdle) & ~rst;
  assign w_access   = (r_state == StAccess) & ~rst;
  assign w_accept   = w_idle & req_valid;
  assign w_in_range = ({1'b0, req_addr} < MemLim);

  mu0_wait_ctr #(
    .WAIT (WAIT)
  ) u_wait_ctr (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_accept),
    .i_inc  (w_access),
    .o_done (w_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_write <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (req_valid) begin
            r_write <= req_write;
            r_wdata <= req_wdata;
            r_err   <= ~w_in_range;
            if (w_in_range) begin
              // The bus address only moves for accesses that actually reach memory.
              r_addr  <= req_addr;
              r_state <= StAccess;
            end else begin
              r_rdata <= '0;
              r_state <= StResp;
            end
          end
        end
        StAccess: begin
          if (w_done) begin
            if (!r_write) begin
              r_rdata <= databus;
            end
            r_state <= StResp;
          end
        end
        StResp: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  // Gated with rst so the request and the write driver fall the instant reset rises.
  assign w_drive   = w_access & r_write;
  assign databus   = w_drive ? r_wdata : {DATA{1'bz}};

  assign req_ready = w_idle;
  assign mem_rq    = w_access;
  assign rnw       = w_drive ? RnwWrite : RnwRead;
  assign addr      = r_addr;
  assign rsp_valid = (r_state == StResp);
  assign rsp_err   = r_err;
  assign rsp_rdata = r_rdata;

endmodule

// File: tb/tb_mu0_mem_master.sv
// Bench for mu0_mem_master: memory model on the bus, scoreboard of expected responses, and a
// second instance with three wait states.
module tb_mu0_mem_master;

  localparam int MEMW = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   errs = 0;
  int   checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A: WAIT=0, scoreboarded.
  logic        a_req_valid, a_req_ready, a_req_write;
  logic [11:0] a_req_addr;
  logic [15:0] a_req_wdata;
  logic        a_rsp_valid, a_rsp_err, a_mem_rq, a_rnw;
  logic [15:0] a_rsp_rdata;
  logic [11:0] a_addr;
  tri1  [15:0] a_databus;

  // Instance B: WAIT=3, directed timing test.
  logic        b_req_valid, b_req_ready, b_req_write;
  logic [11:0] b_req_addr;
  logic [15:0] b_req_wdata;
  logic        b_rsp_valid, b_rsp_err, b_mem_rq, b_rnw;
  logic [15:0] b_rsp_rdata;
  logic [11:0] b_addr;
  tri1  [15:0] b_databus;

  logic [15:0] mem_a [MEMW];
  logic [15:0] mem_b [MEMW];

  // Released bus floats to all-ones through the tri1 net.
  assign a_databus = (a_mem_rq && a_rnw) ? mem_a[a_addr[4:0]] : 16'hzzzz;
  assign b_databus = (b_mem_rq && b_rnw) ? mem_b[b_addr[4:0]] : 16'hzzzz;

  always @(posedge clk) begin
    if (a_mem_rq && !a_rnw) mem_a[a_addr[4:0]] <= a_databus;
    if (b_mem_rq && !b_rnw) mem_b[b_addr[4:0]] <= b_databus;
  end

  mu0_mem_master #(.ADDR(12), .DATA(16), .MEM(32), .WAIT(0)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .req_valid (a_req_valid),
    .req_ready (a_req_ready),
    .req_write (a_req_write),
    .req_addr  (a_req_addr),
    .req_wdata (a_req_wdata),
    .rsp_valid (a_rsp_valid),
    .rsp_rdata (a_rsp_rdata),
    .rsp_err   (a_rsp_err),
    .mem_rq    (a_mem_rq),
    .rnw       (a_rnw),
    .addr      (a_addr),
    .databus   (a_databus)
  );

  mu0_mem_master #(.ADDR(12), .DATA(16), .MEM(32), .WAIT(3)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .req_valid (b_req_valid),
    .req_ready (b_req_ready),
    .req_write (b_req_write),
    .req_addr  (b_req_addr),
    .req_wdata (b_req_wdata),
    .rsp_valid (b_rsp_valid),
    .rsp_rdata (b_rsp_rdata),
    .rsp_err   (b_rsp_err),
    .mem_rq    (b_mem_rq),
    .rnw       (b_rnw),
    .addr      (b_addr),
    .databus   (b_databus)
  );

  typedef struct {
    logic        err;
    logic [15:0] rdata;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [15:0] ref_mem [MEMW];
  logic [15:0] last_rdata;
  logic [15:0] cur_wdata;
  logic [11:0] cur_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor and bus-ownership checks for instance A.
  always @(negedge clk) begin
    if (a_rsp_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_err", a_rsp_err, mon_e.err);
        chk("rsp_rdata", a_rsp_rdata, mon_e.rdata);
        chk("rsp_cycle", cyc, mon_e.cyc);
      end
    end
    if (a_mem_rq) begin
      if (!a_rnw) begin
        chk("bus_write_data", a_databus, cur_wdata);
        chk("bus_write_addr", a_addr, cur_addr);
      end else begin
        chk("bus_read_contention", a_databus, mem_a[a_addr[4:0]]);
      end
    end else begin
      chk("bus_released", a_databus, 16'hFFFF);
      chk("rnw_idle", a_rnw, 1'b1);
    end
  end

  // Present one request on A (called at a negedge); returns the accepting edge number.
  task automatic send(input logic w, input logic [11:0] ad, input logic [15:0] d,
                      input bit track, output int acc);
    int   n;
    exp_t e;
    a_req_valid = 1'b1;
    a_req_write = w;
    a_req_addr  = ad;
    a_req_wdata = d;
    n = 0;
    while (!a_req_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!a_req_ready) begin
      checks++;
      errs++;
      $display("FAIL accept_timeout: got req_ready=0 expected 1 within 40 cycles");
      a_req_valid = 1'b0;
      acc = -1;
      return;
    end
    acc = cyc + 1;
    if (w) begin
      cur_wdata = d;
      cur_addr  = ad;
    end
    if (track) begin
      e.err = (ad >= 12'(MEMW));
      if (e.err) e.rdata = 16'h0;
      else if (w) begin
        ref_mem[ad[4:0]] = d;
        e.rdata = last_rdata;
      end else e.rdata = ref_mem[ad[4:0]];
      last_rdata = e.rdata;
      e.cyc = e.err ? acc : acc + 1;
      sb.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || !a_req_ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errs++;
      $display("FAIL drain_timeout: got %0d pending responses expected 0", sb.size());
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100000 ns");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc1, acc2, acc3, e0, mhigh, rlow, rsp_at, nrsp;
    logic [15:0] b_rd;
    logic        b_er;

    a_req_valid = 0; a_req_write = 0; a_req_addr = 0; a_req_wdata = 0;
    b_req_valid = 0; b_req_write = 0; b_req_addr = 0; b_req_wdata = 0;
    for (int i = 0; i < MEMW; i++) begin
      mem_a[i] = 16'h0; mem_b[i] = 16'h0; ref_mem[i] = 16'h0;
    end
    mem_b[7] = 16'h1234;
    last_rdata = 16'h0;
    cur_wdata = 16'h0;
    cur_addr = 12'h0;

    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_mem_rq", a_mem_rq, 1'b0);
    chk("rst_rnw", a_rnw, 1'b1);
    chk("rst_addr", a_addr, 12'h0);
    chk("rst_databus", a_databus, 16'hFFFF);
    chk("rst_req_ready", a_req_ready, 1'b0);
    chk("rst_rsp_valid", a_rsp_valid, 1'b0);
    chk("rst_rsp_rdata", a_rsp_rdata, 16'h0);
    chk("rst_rsp_err", a_rsp_err, 1'b0);
    chk("rst_b_ready", b_req_ready, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", a_req_ready, 1'b1);

    // Write 0xBEEF to 5, then read it back.
    send(1'b1, 12'd5, 16'hBEEF, 1'b1, acc);
    a_req_valid = 1'b0;
    chk("wr_mem_rq", a_mem_rq, 1'b1);
    chk("wr_rnw", a_rnw, 1'b0);
    chk("wr_addr", a_addr, 12'd5);
    chk("wr_databus", a_databus, 16'hBEEF);
    @(negedge clk);
    chk("wr_one_cycle", a_mem_rq, 1'b0);
    send(1'b0, 12'd5, 16'h0, 1'b1, acc);
    a_req_valid = 1'b0;
    drain();

    // Out-of-range read never touches the bus.
    send(1'b0, 12'd32, 16'h0, 1'b1, acc);
    a_req_valid = 1'b0;
    chk("oor_no_mem_rq", a_mem_rq, 1'b0);
    @(negedge clk);
    chk("oor_no_mem_rq2", a_mem_rq, 1'b0);
    drain();

    // Back-to-back writes with valid held high.
    send(1'b1, 12'd1, 16'h0001, 1'b1, acc1);
    send(1'b1, 12'd2, 16'h0002, 1'b1, acc2);
    send(1'b1, 12'd3, 16'h0003, 1'b1, acc3);
    a_req_valid = 1'b0;
    chk("b2b_gap_1", acc2 - acc1, 3);
    chk("b2b_gap_2", acc3 - acc2, 3);
    drain();
    for (int i = 1; i <= 3; i++) chk("b2b_mem", mem_a[i], 16'(i));
    for (int i = 1; i <= 3; i++) begin
      send(1'b0, 12'(i), 16'h0, 1'b1, acc);
    end
    a_req_valid = 1'b0;
    drain();

    // Reset during the ACCESS cycle of a write must abort it.
    send(1'b1, 12'd9, 16'h5555, 1'b1, acc);
    a_req_valid = 1'b0;
    drain();
    send(1'b1, 12'd9, 16'hAAAA, 1'b0, acc);
    a_req_valid = 1'b0;
    chk("mid_rst_in_access", a_mem_rq, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_mem_rq_drop", a_mem_rq, 1'b0);
    chk("mid_rst_bus_release", a_databus, 16'hFFFF);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    last_rdata = 16'h0;
    @(negedge clk);
    chk("mid_rst_mem_kept", mem_a[9], 16'h5555);
    send(1'b0, 12'd9, 16'h0, 1'b1, acc);
    a_req_valid = 1'b0;
    drain();

    // Random mix, including some out-of-range addresses.
    for (int i = 0; i < 200; i++) begin
      send(1'($urandom_range(0, 1)), 12'($urandom_range(0, 35)), 16'($urandom), 1'b1, acc);
      if ($urandom_range(0, 1) == 1) begin
        a_req_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end
    a_req_valid = 1'b0;
    drain();

    // WAIT=3 read of address 7 on instance B.
    chk("b_ready_before", b_req_ready, 1'b1);
    b_req_valid = 1'b1;
    b_req_write = 1'b0;
    b_req_addr  = 12'd7;
    @(negedge clk);
    b_req_valid = 1'b0;
    e0 = cyc;
    mhigh = 0; rlow = 0; rsp_at = -1; nrsp = 0; b_rd = 16'h0; b_er = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (b_mem_rq) mhigh++;
      if (!b_req_ready) rlow++;
      if (b_rsp_valid) begin
        nrsp++;
        if (rsp_at < 0) begin
          rsp_at = cyc - e0;
          b_rd = b_rsp_rdata;
          b_er = b_rsp_err;
        end
      end
      @(negedge clk);
    end
    chk("wait_mem_rq_cycles", mhigh, 4);
    chk("wait_ready_low_cycles", rlow, 5);
    chk("wait_rsp_offset", rsp_at, 4);
    chk("wait_rsp_count", nrsp, 1);
    chk("wait_rsp_rdata", b_rd, 16'h1234);
    chk("wait_rsp_err", b_er, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
